spm_ctrl: RTL and testbench
===========================

SPM_CTRL -- requirements
Module: spm_ctrl

Interface
REQ-001 Parameter N, default 8: operand width in bits, two's complement; legal N >= 2.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  single-cycle start pulse from the team's edge-detector block.
REQ-005 a_in  in  N  signed multiplicand.
REQ-006 b_in  in  N  signed multiplier.
REQ-007 spm_a  out  N  registered multiplicand, driven to the serial-parallel multiplier (SPM) parallel input.
REQ-008 spm_clr  out  1  SPM accumulator/carry clear strobe.
REQ-009 spm_en  out  1  SPM shift enable.
REQ-010 spm_x  out  1  serial multiplier bit, LSB first.
REQ-011 spm_p  in  1  serial product bit from the SPM, valid in the same cycle as spm_x.
REQ-012 busy  out  1  high while an operation is in progress.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 product  out  2N  signed product, held until the next accepted start.

Function
REQ-015 FSM states: IDLE, CLEAR, RUN, DONE; encoded state register, next-state logic fully combinational with default to IDLE.
REQ-016 IDLE: start=1 shall capture a_in into spm_a and b_in into an internal multiplier register, then go to CLEAR; start=0 stays in IDLE.
REQ-017 CLEAR: spm_clr=1 for exactly one cycle, bit counter k cleared to 0, product register cleared to 0, then go to RUN.
REQ-018 RUN lasts exactly 2N cycles, k = 0..2N-1; spm_en=1 on every RUN cycle.
REQ-019 spm_x in RUN cycle k shall be b[k] for k < N and b[N-1] (sign extension) for k >= N.
REQ-020 At the end of each RUN cycle, the product register shifts right with spm_p entering at the MSB: product <= {spm_p, product[2N-1:1]}.
REQ-021 On the last RUN cycle (k = 2N-1), the FSM shall go to DONE.
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE; product holds the complete 2N-bit result from the DONE cycle onward.
REQ-023 busy=1 in CLEAR, RUN and DONE; busy=0 in IDLE.
REQ-024 Latency: start sampled at edge T0 -> CLEAR in cycle T0+1 -> RUN in cycles T0+2..T0+2N+1 -> done=1 in cycle T0+2N+2.
REQ-025 start when busy=1 shall be ignored: no recapture, no restart, no effect on the timing or on the result.
REQ-026 start asserted in the DONE cycle is ignored; a new start is accepted only in IDLE.
REQ-027 spm_clr, spm_en and spm_x shall be 0 outside the states defined for them.
REQ-028 The counter shall be wide enough to hold 2N-1 and shall not wrap within an operation.
REQ-029 a_in and b_in changes after capture shall not affect the operation in flight.

Reset
REQ-030 rst=1 at a clock edge forces IDLE, from any state including mid-RUN.
REQ-031 Reset values: busy=0, done=0, spm_clr=0, spm_en=0, spm_x=0, spm_a=0, product=0, counter=0.
REQ-032 rst has priority over start in the same cycle.
REQ-033 An operation interrupted by reset shall produce no done pulse.

Verification
(The bench uses a behavioural signed SPM model connected to the spm_* ports.)
REQ-034 N=8, a=3, b=5, one start pulse -> done exactly 18 cycles after start; product=16'h000F.
REQ-035 a=-3, b=5 -> product=16'hFFF1; a=5, b=-3 -> product=16'hFFF1.
REQ-036 a=-128, b=-128 -> product=16'h4000; a=127, b=-128 -> product=16'hC080.
REQ-037 A second start pulse in RUN cycle 4 with different operands -> no effect; single done at the original time, with the first operands' product.
REQ-038 rst asserted in RUN cycle 7 -> busy=0 and all outputs at reset values in the next cycle; no done pulse; a following start with a=2, b=-2 -> product=16'hFFFC.
REQ-039 Back-to-back operations with start in the first IDLE cycle after DONE -> both accepted, with correct products and done pulses 19 cycles apart.

Source files
------------

// File: rtl/spm_ctrl.sv
// Controller for a serial-parallel multiplier: feeds the multiplier bits LSB first with sign extension and collects the 2N-bit product.
// Latency is 2N+2 cycles from start to done. Starts arriving while busy are ignored, and there is no backpressure.
module spm_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic [N-1:0]   spm_a,
    output logic           spm_clr,
    output logic           spm_en,
    output logic           spm_x,
    input  logic           spm_p,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int KW = $clog2(2 * N);
    localparam logic [KW-1:0] K_LAST = KW'(2 * N - 1);
    localparam logic [KW-1:0] K_N    = KW'(N);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  b_shr;
    logic [KW-1:0] k;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            spm_a   <= '0;
            b_reg   <= '0;
            k       <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        spm_a <= a_in;
                        b_reg <= b_in;
                    end
                end
                CLEAR: begin
                    k       <= '0;
                    product <= '0;
                end
                RUN: begin
                    product <= {spm_p, product[2*N-1:1]};
                    if (k != K_LAST) begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = IDLE;
        spm_clr   = 1'b0;
        spm_en    = 1'b0;
        spm_x     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        b_shr     = b_reg >> k;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                state_nxt = start ? CLEAR : IDLE;
            end
            CLEAR: begin
                spm_clr   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                spm_en    = 1'b1;
                // Upper half of the run replays the sign bit of the multiplier.
                spm_x     = (k < K_N) ? b_shr[0] : b_reg[N-1];
                state_nxt = (k == K_LAST) ? DONE : RUN;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spm_ctrl.sv
// Bench for spm_ctrl with N=8: a behavioural SPM model is attached, and products and done timing are scoreboarded against plain signed multiplication.
module tb_spm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [7:0]  spm_a;
    logic        spm_clr;
    logic        spm_en;
    logic        spm_x;
    logic        spm_p;
    logic        busy;
    logic        done;
    logic [15:0] product;

    spm_ctrl #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .spm_a(spm_a), .spm_clr(spm_clr), .spm_en(spm_en), .spm_x(spm_x),
        .spm_p(spm_p), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial-parallel multiplier model: a running signed residue, with one product bit emitted per enabled cycle.
    longint acc = 0;
    longint a_s;
    longint sum;
    always_comb begin
        a_s   = longint'($signed(spm_a));
        sum   = acc + (spm_x ? a_s : 64'sd0);
        spm_p = spm_en & sum[0];
    end
    always @(posedge clk) begin
        if (rst || spm_clr) acc <= 0;
        else if (spm_en)    acc <= sum >>> 1;
    end

    typedef struct {
        logic [15:0] prod;
        int unsigned due;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        longint r;
        r = longint'($signed(a)) * longint'($signed(b));
        return r[15:0];
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending operation", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.due);
                check("product", product, e.prod);
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, output int unsigned t0);
        exp_t e;
        @(negedge clk);
        a_in   = a;
        b_in   = b;
        start  = 1'b1;
        t0     = cyc;
        e.prod = ref_mul(a, b);
        e.due  = cyc + 18;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        if (!done) begin
            checks++;
            $display("FAIL done_timeout: done=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 60);
        if (busy || exp_q.size() != 0) begin
            checks++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d, required idle", busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_done"},    done,    0);
        check({tag, "_spm_clr"}, spm_clr, 0);
        check({tag, "_spm_en"},  spm_en,  0);
        check({tag, "_spm_x"},   spm_x,   0);
        check({tag, "_spm_a"},   spm_a,   0);
        check({tag, "_product"}, product, 0);
    endtask

    typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] lit; } dir_t;
    dir_t dirs[5];

    initial begin
        int unsigned t0;
        logic [7:0] ra;
        logic [7:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        dirs[0] = '{8'd3,   8'd5,   16'h000F};
        dirs[1] = '{8'hFD,  8'd5,   16'hFFF1};
        dirs[2] = '{8'd5,   8'hFD,  16'hFFF1};
        dirs[3] = '{8'h80,  8'h80,  16'h4000};
        dirs[4] = '{8'd127, 8'h80,  16'hC080};
        foreach (dirs[i]) begin
            issue(dirs[i].a, dirs[i].b, t0);
            wait_idle();
            check("directed_literal", product, dirs[i].lit);
        end

        // Start pulse during RUN cycle 4 with different operands must be ignored.
        issue(8'd7, 8'd9, t0);
        while (cyc < t0 + 6) @(negedge clk);
        a_in  = 8'h55;
        b_in  = 8'h66;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("no_recapture", spm_a, 8'd7);
        wait_idle();
        check("ignored_start_product", product, 16'd63);

        // Start in the DONE cycle must be ignored.
        issue(8'd10, 8'hF6, t0);
        wait_done();
        start = 1'b1;
        a_in  = 8'd1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_ignored", busy, 0);
        check("product_held", product, 16'hFF9C);

        // Reset asserted in RUN cycle 7 aborts the operation with no done pulse.
        issue(8'd11, 8'hF3, t0);
        while (cyc < t0 + 9) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("midrun_reset");
        repeat (25) @(negedge clk);
        issue(8'd2, 8'hFE, t0);
        wait_idle();
        check("after_reset_product", product, 16'hFFFC);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 8'd9;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_priority_busy", busy, 0);
        check("rst_priority_spm_a", spm_a, 0);

        // Back-to-back: second start in the first IDLE cycle after DONE.
        issue(8'd100, 8'hC8, t0);
        wait_done();
        issue(8'hE7, 8'd33, t0);
        wait_idle();

        // Randomized operations, mixing back-to-back issue with idle gaps.
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            issue(ra, rb, t0);
            if ($urandom_range(0, 1) == 1) begin
                wait_done();
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
